fft_frame_ctrl: RTL and testbench

Sequencer for the streaming FFT core in the chirp/ADC datapath, running in the 245.76 MHz domain.
- On a start request it programs the FFT configuration channel with one config word.
- It then gates ADC sample beats into the FFT data input and generates tlast every NFFT samples.
- It counts input and output frames against a programmed frame count, and latches the FFT event flags into sticky status.

---
 rtl/fft_frame_ctrl.sv | 155 +++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the streaming FFT core: issues one config beat per run,
// gates ADC beats into the core with tlast framing, counts frames and latches event flags.
module fft_frame_ctrl #(
   parameter int DATA_WIDTH      = 32,
   parameter int CFG_WIDTH       = 24,
   parameter int MAX_NFFT_LOG2   = 16,
   parameter int FRAME_CNT_WIDTH = 16
) (
   input  logic                       clk_245,
   input  logic                       clk_245_rst,
   input  logic                       start,
   input  logic                       abort,
   input  logic [4:0]                 nfft_log2,
   input  logic                       fwd_inv,
   input  logic [5:0]                 scale_sch,
   input  logic [FRAME_CNT_WIDTH-1:0] frame_count,
   input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   output logic [CFG_WIDTH-1:0]       fft_cfg_tdata,
   output logic                       fft_cfg_tvalid,
   input  logic                       fft_cfg_tready,
   output logic [DATA_WIDTH-1:0]      fft_in_tdata,
   output logic                       fft_in_tvalid,
   input  logic                       fft_in_tready,
   output logic                       fft_in_tlast,
   input  logic                       fft_out_tvalid,
   input  logic                       fft_out_tlast,
   input  logic                       m_axis_tready,
   input  logic                       ev_tlast_unexpected,
   input  logic                       ev_tlast_missing,
   input  logic                       ev_data_in_halt,
   output logic                       busy,
   output logic                       done,
   output logic [FRAME_CNT_WIDTH-1:0] frames_in,
   output logic [FRAME_CNT_WIDTH-1:0] frames_out,
   output logic [3:0]                 err_status
);

   typedef enum logic [1:0] {IDLE, CONFIG, RUN, DRAIN} state_t;

   state_t                     state;
   state_t                     state_next;
   logic [4:0]                 nfft_clamped;
   logic [4:0]                 nfft_q;
   logic [FRAME_CNT_WIDTH-1:0] frame_count_q;
   logic [FRAME_CNT_WIDTH-1:0] frames_in_inc;
   logic [MAX_NFFT_LOG2-1:0]   sample_cnt;
   logic [MAX_NFFT_LOG2-1:0]   last_idx;
   logic                       in_hs;
   logic                       at_last;
   logic                       abort_now;
   logic                       out_frame;

   always_comb begin
      nfft_clamped = nfft_log2;
      if (nfft_log2 < 5'd3)
         nfft_clamped = 5'd3;
      else if (nfft_log2 > 5'(MAX_NFFT_LOG2))
         nfft_clamped = 5'(MAX_NFFT_LOG2);
   end

   // 2^nfft - 1 built by shifting an all-ones word, so nfft == MAX_NFFT_LOG2 needs no extra bit
   assign last_idx      = {MAX_NFFT_LOG2{1'b1}} >> (5'(MAX_NFFT_LOG2) - nfft_q);
   assign at_last       = (sample_cnt == last_idx);
   assign busy          = (state != IDLE);
   assign in_hs         = (state == RUN) && s_axis_tvalid && fft_in_tready;
   assign abort_now     = abort && busy;
   assign out_frame     = busy && fft_out_tvalid && fft_out_tlast && m_axis_tready;
   assign frames_in_inc = frames_in + 1'b1;

   always_ff @(posedge clk_245) begin
      if (clk_245_rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next     = state;
      s_axis_tready  = 1'b0;
      fft_in_tvalid  = 1'b0;
      fft_in_tlast   = 1'b0;
      fft_cfg_tvalid = 1'b0;
      done           = 1'b0;
      fft_in_tdata   = s_axis_tdata;
      case (state)
         IDLE: begin
            if (start)
               state_next = CONFIG;
         end
         CONFIG: begin
            fft_cfg_tvalid = 1'b1;
            if (fft_cfg_tready)
               state_next = RUN;
         end
         RUN: begin
            s_axis_tready = fft_in_tready;
            fft_in_tvalid = s_axis_tvalid;
            fft_in_tlast  = at_last;
            if (in_hs && at_last && (frame_count_q != '0) && (frames_in_inc == frame_count_q))
               state_next = DRAIN;
         end
         DRAIN: begin
            if (frames_out == frame_count_q) begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      // Abort wins over every other transition, including a completing drain
      if (abort_now) begin
         done       = 1'b0;
         state_next = IDLE;
      end
   end

   always_ff @(posedge clk_245) begin
      if (clk_245_rst) begin
         nfft_q        <= 5'd3;
         frame_count_q <= '0;
         fft_cfg_tdata <= '0;
         sample_cnt    <= '0;
         frames_in     <= '0;
         frames_out    <= '0;
         err_status    <= '0;
      end else if (state == IDLE && start) begin
         nfft_q        <= nfft_clamped;
         frame_count_q <= frame_count;
         fft_cfg_tdata <= CFG_WIDTH'({scale_sch, fwd_inv, 3'b000, nfft_clamped});
         sample_cnt    <= '0;
         frames_in     <= '0;
         frames_out    <= '0;
         err_status    <= '0;
      end else begin
         if (busy)
            err_status <= err_status |
                          {abort, ev_data_in_halt, ev_tlast_missing, ev_tlast_unexpected};
         if (out_frame)
            frames_out <= frames_out + 1'b1;
         if (abort_now) begin
            sample_cnt <= '0;
         end else if (in_hs) begin
            if (at_last) begin
               sample_cnt <= '0;
               frames_in  <= frames_in_inc;
            end else begin
               sample_cnt <= sample_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: a frame-level reference model checked every cycle,
// plus directed scenarios with literal expectations on config words, tlast positions and counts.
module tb_fft_frame_ctrl;

   logic        clk_245 = 1'b0;
   logic        clk_245_rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [4:0]  nfft_log2 = 5'd3;
   logic        fwd_inv = 1'b0;
   logic [5:0]  scale_sch = 6'd0;
   logic [15:0] frame_count = 16'd0;
   logic [31:0] s_axis_tdata = 32'd0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [23:0] fft_cfg_tdata;
   logic        fft_cfg_tvalid;
   logic        fft_cfg_tready = 1'b0;
   logic [31:0] fft_in_tdata;
   logic        fft_in_tvalid;
   logic        fft_in_tready = 1'b0;
   logic        fft_in_tlast;
   logic        fft_out_tvalid = 1'b0;
   logic        fft_out_tlast = 1'b0;
   logic        m_axis_tready = 1'b0;
   logic        ev_tlast_unexpected = 1'b0;
   logic        ev_tlast_missing = 1'b0;
   logic        ev_data_in_halt = 1'b0;
   logic        busy;
   logic        done;
   logic [15:0] frames_in;
   logic [15:0] frames_out;
   logic [3:0]  err_status;

   int n_vec = 0;
   int n_bad = 0;
   bit stream_on = 1'b0;
   bit rand_gaps = 1'b0;

   // Reference model: run phase flags, position within frame, frame tallies, sticky errors
   bit          m_busy = 1'b0;
   bit          m_pend = 1'b0;
   bit          m_drain = 1'b0;
   int          m_cnt = 0;
   int          m_period = 8;
   logic [15:0] m_fc = '0;
   logic [15:0] m_fin = '0;
   logic [15:0] m_fout = '0;
   logic [3:0]  m_err = '0;
   logic [23:0] m_cfg = '0;
   logic        run_q;
   logic        exp_done;
   int          clamp_v;

   int tb_hs = 0;
   int cfg_hs = 0;
   int cfg_wait = 0;
   int done_cnt = 0;
   int last_pos[$];

   fft_frame_ctrl dut (
      .clk_245(clk_245), .clk_245_rst(clk_245_rst), .start(start), .abort(abort),
      .nfft_log2(nfft_log2), .fwd_inv(fwd_inv), .scale_sch(scale_sch),
      .frame_count(frame_count), .s_axis_tdata(s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .fft_cfg_tdata(fft_cfg_tdata), .fft_cfg_tvalid(fft_cfg_tvalid),
      .fft_cfg_tready(fft_cfg_tready), .fft_in_tdata(fft_in_tdata),
      .fft_in_tvalid(fft_in_tvalid), .fft_in_tready(fft_in_tready),
      .fft_in_tlast(fft_in_tlast), .fft_out_tvalid(fft_out_tvalid),
      .fft_out_tlast(fft_out_tlast), .m_axis_tready(m_axis_tready),
      .ev_tlast_unexpected(ev_tlast_unexpected), .ev_tlast_missing(ev_tlast_missing),
      .ev_data_in_halt(ev_data_in_halt), .busy(busy), .done(done),
      .frames_in(frames_in), .frames_out(frames_out), .err_status(err_status)
   );

   always #2 clk_245 = ~clk_245;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare outputs against the model mid-cycle, then advance the model with the inputs
   // the DUT will sample on the coming rising edge
   always @(negedge clk_245) begin
      run_q    = m_busy && !m_pend && !m_drain;
      exp_done = m_busy && m_drain && (m_fout == m_fc) && !abort;
      checkOutput("busy", busy, m_busy);
      checkOutput("cfg_tvalid", fft_cfg_tvalid, m_pend && m_busy);
      checkOutput("s_tready", s_axis_tready, run_q && fft_in_tready);
      checkOutput("in_tvalid", fft_in_tvalid, run_q && s_axis_tvalid);
      checkOutput("in_tlast", fft_in_tlast, run_q && (m_cnt == m_period - 1));
      checkOutput("done", done, exp_done);
      checkOutput("frames_in", frames_in, m_fin);
      checkOutput("frames_out", frames_out, m_fout);
      checkOutput("err_status", err_status, m_err);
      checkOutput("cfg_tdata", fft_cfg_tdata, m_cfg);
      if (run_q)
         checkOutput("in_tdata", fft_in_tdata, s_axis_tdata);

      if (fft_in_tvalid && fft_in_tready) begin
         tb_hs++;
         if (fft_in_tlast)
            last_pos.push_back(tb_hs);
      end
      if (fft_cfg_tvalid) begin
         if (fft_cfg_tready) cfg_hs++;
         else cfg_wait++;
      end
      if (done)
         done_cnt++;

      if (clk_245_rst) begin
         m_busy = 0; m_pend = 0; m_drain = 0; m_cnt = 0;
         m_fin = '0; m_fout = '0; m_err = '0; m_cfg = '0;
      end else if (!m_busy) begin
         if (start) begin
            clamp_v  = (nfft_log2 < 3) ? 3 : (nfft_log2 > 16) ? 16 : int'(nfft_log2);
            m_period = 1 << clamp_v;
            m_cfg    = 24'(clamp_v + 256 * int'(fwd_inv) + 512 * int'(scale_sch));
            m_fc     = frame_count;
            m_busy = 1; m_pend = 1; m_drain = 0; m_cnt = 0;
            m_fin = '0; m_fout = '0; m_err = '0;
            tb_hs = 0; cfg_hs = 0; cfg_wait = 0; done_cnt = 0;
            last_pos.delete();
         end
      end else begin
         m_err = m_err | {abort, ev_data_in_halt, ev_tlast_missing, ev_tlast_unexpected};
         if (fft_out_tvalid && fft_out_tlast && m_axis_tready)
            m_fout = m_fout + 16'd1;
         if (abort) begin
            m_busy = 0; m_pend = 0; m_drain = 0; m_cnt = 0;
         end else if (m_pend) begin
            if (fft_cfg_tready) m_pend = 0;
         end else if (m_drain) begin
            if (exp_done) begin m_busy = 0; m_drain = 0; end
         end else if (s_axis_tvalid && fft_in_tready) begin
            if (m_cnt == m_period - 1) begin
               m_cnt = 0;
               m_fin = m_fin + 16'd1;
               if (m_fc != 0 && m_fin == m_fc) m_drain = 1;
            end else begin
               m_cnt++;
            end
         end
      end
   end

   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_245);
         #1;
         start = 0; abort = 0;
         ev_tlast_unexpected = 0; ev_tlast_missing = 0; ev_data_in_halt = 0;
         if (stream_on) begin
            s_axis_tvalid = rand_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            fft_in_tready = rand_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            s_axis_tdata  = $urandom;
         end else begin
            s_axis_tvalid = 0;
            fft_in_tready = 0;
         end
      end
   endtask

   task automatic outputBeats(input int n);
      for (int i = 0; i < n; i++) begin
         fft_out_tvalid = 1; fft_out_tlast = 1; m_axis_tready = 1;
         applyStimulus(1);
         fft_out_tvalid = 0; fft_out_tlast = 0; m_axis_tready = 0;
         applyStimulus(1);
      end
   endtask

   task automatic waitDone(input int max_cycles);
      int k = 0;
      while (done_cnt == 0 && k < max_cycles) begin
         applyStimulus(1);
         k++;
      end
      checkOutput("done_pulses", done_cnt, 1);
   endtask

   task automatic startRun(input logic [4:0] n, input logic fi, input logic [5:0] sc,
                           input logic [15:0] fc);
      nfft_log2 = n; fwd_inv = fi; scale_sch = sc; frame_count = fc;
      start = 1;
      applyStimulus(1);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      applyStimulus(3);
      clk_245_rst = 0;
      applyStimulus(1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_err", err_status, 0);
      checkOutput("rst_cfg", fft_cfg_tdata, 0);

      // Config held off for three cycles, then two 64-point frames
      fft_cfg_tready = 0;
      startRun(5'd6, 1'b1, 6'h2A, 16'd2);
      applyStimulus(3);
      checkOutput("cfg_wait_cycles", cfg_wait, 3);
      fft_cfg_tready = 1;
      stream_on = 1; rand_gaps = 0;
      applyStimulus(1);
      checkOutput("cfg_word_6", fft_cfg_tdata, 24'h005506);
      checkOutput("cfg_beats", cfg_hs, 1);
      start = 1; ev_tlast_missing = 1;
      applyStimulus(140);
      checkOutput("two_frames_in", frames_in, 2);
      checkOutput("tlast_count", last_pos.size(), 2);
      checkOutput("tlast_pos0", last_pos[0], 64);
      checkOutput("tlast_pos1", last_pos[1], 128);
      checkOutput("beats_total", tb_hs, 128);
      checkOutput("drain_busy", busy, 1);
      checkOutput("cfg_beats_after", cfg_hs, 1);
      stream_on = 0;
      outputBeats(2);
      waitDone(10);
      checkOutput("frames_out_2", frames_out, 2);
      checkOutput("err_missing", err_status, 4'b0010);
      checkOutput("idle_after_done", busy, 0);

      // 8-point frames with random gaps on both sides of the handshake
      startRun(5'd3, 1'b0, 6'h00, 16'd3);
      checkOutput("start_clears_err", err_status, 0);
      stream_on = 1; rand_gaps = 1;
      for (int k = 0; k < 2000 && tb_hs < 24; k++)
         applyStimulus(1);
      applyStimulus(3);
      stream_on = 0; rand_gaps = 0;
      checkOutput("gap_beats", tb_hs, 24);
      checkOutput("gap_tlast_count", last_pos.size(), 3);
      checkOutput("gap_tlast0", last_pos[0], 8);
      checkOutput("gap_tlast1", last_pos[1], 16);
      checkOutput("gap_tlast2", last_pos[2], 24);
      outputBeats(3);
      waitDone(10);

      // Continuous mode, abort three beats into the sixth frame
      fft_cfg_tready = 1;
      stream_on = 1;
      startRun(5'd3, 1'b1, 6'h01, 16'd0);
      for (int k = 0; k < 200 && tb_hs < 43; k++)
         applyStimulus(1);
      abort = 1;
      applyStimulus(1);
      stream_on = 0;
      checkOutput("cont_frames_in", frames_in, 5);
      checkOutput("abort_idle", busy, 0);
      checkOutput("abort_err", err_status, 4'b1000);
      applyStimulus(2);
      checkOutput("abort_no_done", done_cnt, 0);

      // Undersized transform clamps up to 8 points
      stream_on = 1;
      startRun(5'd1, 1'b0, 6'h00, 16'd1);
      checkOutput("cfg_clamp_lo", fft_cfg_tdata, 24'h000003);
      applyStimulus(12);
      stream_on = 0;
      checkOutput("clamp_tlast_count", last_pos.size(), 1);
      checkOutput("clamp_tlast0", last_pos[0], 8);
      outputBeats(1);
      waitDone(10);

      // Oversized transform clamps down; abort while config is pending
      fft_cfg_tready = 0;
      startRun(5'd20, 1'b0, 6'h00, 16'd1);
      checkOutput("cfg_clamp_hi", fft_cfg_tdata, 24'h000010);
      abort = 1;
      applyStimulus(1);
      checkOutput("cfg_abort_idle", busy, 0);
      checkOutput("cfg_abort_err", err_status, 4'b1000);
      checkOutput("cfg_abort_beats", cfg_hs, 0);

      // Reset in the middle of a run
      fft_cfg_tready = 1;
      stream_on = 1;
      startRun(5'd3, 1'b0, 6'h00, 16'd0);
      applyStimulus(6);
      clk_245_rst = 1;
      applyStimulus(1);
      clk_245_rst = 0;
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_frames", frames_in, 0);
      checkOutput("midrst_cfg", fft_cfg_tdata, 0);
      applyStimulus(3);
      stream_on = 0;
      applyStimulus(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
